// File: rtl/sdctrl_spi_host.sv
// sdctrl_spi_host: SPI-mode SD host engine (command + CRC7, R1 poll, R3/R7 trailer or one data block)
// Optional build macro SDCTRL_SPI_CRC16_CHECK_EN: verify CRC16-CCITT of the received block (err=3 on mismatch).
module sdctrl_spi_host #(
    parameter int SCLK_DIV      = 4,
    parameter int BLOCK_BYTES   = 512,
    parameter int RESP_TIMEOUT  = 8,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [5:0]  i_req_cmd,
    input  logic [31:0] i_req_arg,
    input  logic [1:0]  i_req_mode,
    output logic        o_resp_valid,
    output logic [7:0]  o_resp_r1,
    output logic [31:0] o_resp_data,
    output logic [1:0]  o_resp_err,
    output logic        o_data_valid,
    output logic [7:0]  o_data_byte,
    output logic        o_data_last,
    output logic        o_csn,
    output logic        o_sck,
    output logic        o_mosi,
    input  logic        i_miso
);
    localparam int DW = $clog2(SCLK_DIV);

    typedef enum logic [3:0] {
        IDLE, INIT, CSN_LEAD, CMD_TX, R1_WAIT, TRAILER, TOKEN_WAIT, DATA_RX, CRC_RX, TAIL, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic [3:0]    h_q;
    logic [7:0]    tx_q, rx_q;
    logic [10:0]   bc_q;
    logic [47:0]   frame_q;
    logic [1:0]    mode_q;
    logic [7:0]    r1_q;
    logic [31:0]   data_q;
    logic [1:0]    err_q;
    logic          dv_q, dl_q;
    logic [7:0]    db_q;
    logic          crc_bad;

    // h_q counts SCK half-periods within a byte; even->odd is a rising edge, so h_q[0] is SCK itself
    wire accept    = i_req_valid && state_q == IDLE;
    wire run       = state_q != IDLE && state_q != DONE;
    wire tick      = run && div_q == DW'(SCLK_DIV - 1);
    wire samp8     = tick && h_q == 4'd14;
    wire byte_done = tick && h_q == 4'd15;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--)
            c = {c[5:0], 1'b0} ^ ((c[6] ^ d[i]) ? 7'h09 : 7'h00);
        return c;
    endfunction

`ifdef SDCTRL_SPI_CRC16_CHECK_EN
    logic [15:0] crc_q;
    logic [7:0]  crc_hi_q;
    assign crc_bad = crc_q != {crc_hi_q, rx_q};
    // running CRC16 over every block bit, plus the first received CRC byte
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            crc_q    <= '0;
            crc_hi_q <= '0;
        end else if (accept) begin
            crc_q    <= '0;
        end else begin
            if (tick && !h_q[0] && state_q == DATA_RX)
                crc_q <= {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ i_miso) ? 16'h1021 : 16'h0000);
            if (byte_done && state_q == CRC_RX)
                crc_hi_q <= rx_q;
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next-state: everything except IDLE/DONE advances only on a byte boundary
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (i_req_valid) state_d = (i_req_mode == 2'd3) ? INIT : CSN_LEAD;
            INIT:       if (byte_done && bc_q == 11'd9) state_d = DONE;
            CSN_LEAD:   if (byte_done) state_d = CMD_TX;
            CMD_TX:     if (byte_done && bc_q == 11'd5) state_d = R1_WAIT;
            R1_WAIT:    if (byte_done)
                            state_d = !rx_q[7] ? ((mode_q == 2'd1) ? TRAILER :
                                                  (mode_q == 2'd2 && rx_q == 8'h00) ? TOKEN_WAIT : TAIL) :
                                      (bc_q == 11'(RESP_TIMEOUT - 1)) ? TAIL : R1_WAIT;
            TRAILER:    if (byte_done && bc_q == 11'd3) state_d = TAIL;
            TOKEN_WAIT: if (byte_done)
                            state_d = (rx_q == 8'hFE) ? DATA_RX :
                                      (rx_q[7:4] == 4'h0 || bc_q == 11'(TOKEN_TIMEOUT - 1)) ? TAIL : TOKEN_WAIT;
            DATA_RX:    if (byte_done && bc_q == 11'(BLOCK_BYTES - 1)) state_d = CRC_RX;
            CRC_RX:     if (byte_done && bc_q == 11'd1) state_d = TAIL;
            TAIL:       if (byte_done) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // byte engine, request latch, response capture and block byte stream
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            div_q   <= '0;
            h_q     <= '0;
            tx_q    <= 8'hFF;
            rx_q    <= 8'hFF;
            bc_q    <= '0;
            frame_q <= '0;
            mode_q  <= '0;
            r1_q    <= '0;
            data_q  <= '0;
            err_q   <= '0;
            dv_q    <= 1'b0;
            dl_q    <= 1'b0;
            db_q    <= '0;
        end else begin
            dv_q <= samp8 && state_q == DATA_RX;
            dl_q <= samp8 && state_q == DATA_RX && bc_q == 11'(BLOCK_BYTES - 1);
            if (samp8 && state_q == DATA_RX) db_q <= {rx_q[6:0], i_miso};
            if (accept) begin
                mode_q  <= i_req_mode;
                frame_q <= {2'b01, i_req_cmd, i_req_arg, crc7({2'b01, i_req_cmd, i_req_arg}), 1'b1};
                r1_q    <= 8'hFF;
                data_q  <= '0;
                err_q   <= '0;
                bc_q    <= '0;
                div_q   <= '0;
                h_q     <= '0;
                tx_q    <= 8'hFF;
            end else if (run) begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    h_q <= h_q + 4'd1;
                    if (!h_q[0]) rx_q <= {rx_q[6:0], i_miso};
                    else         tx_q <= {tx_q[6:0], 1'b1};
                end
                if (byte_done) begin
                    bc_q <= (state_d != state_q) ? '0 : (&bc_q ? bc_q : bc_q + 11'd1);
                    tx_q <= (state_d == CMD_TX) ? frame_q[47:40] : 8'hFF;
                    if (state_d == CMD_TX) frame_q <= frame_q << 8;
                    if (state_q == R1_WAIT && !rx_q[7]) r1_q <= rx_q;
                    if (state_q == TRAILER) data_q <= {data_q[23:0], rx_q};
                    if (state_d == TAIL)
                        err_q <= (state_q == R1_WAIT && rx_q[7]) ? 2'd1 :
                                 (state_q == TOKEN_WAIT) ? 2'd2 :
                                 (state_q == CRC_RX && crc_bad) ? 2'd3 : err_q;
                end
            end
        end
    end

    // outputs: CSn high outside a framed transaction, MOSI idles high
    always_comb begin
        o_req_ready  = state_q == IDLE;
        o_resp_valid = state_q == DONE;
        o_csn        = state_q == IDLE || state_q == INIT || state_q == DONE;
        o_sck        = h_q[0];
        o_mosi       = run ? tx_q[7] : 1'b1;
        o_resp_r1    = r1_q;
        o_resp_data  = data_q;
        o_resp_err   = err_q;
        o_data_valid = dv_q;
        o_data_byte  = db_q;
        o_data_last  = dl_q;
    end
endmodule

// File: tb/tb_sdctrl_spi_host.sv
// tb_sdctrl_spi_host: directed checks of the SPI SD host against a byte-scripted card model
module tb_sdctrl_spi_host;
    logic        clk = 1'b0, nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic [5:0]  req_cmd = '0;
    logic [31:0] req_arg = '0;
    logic [1:0]  req_mode = '0;
    logic        miso = 1'b1;
    logic        req_ready, resp_valid, data_valid, data_last, csn, sck, mosi;
    logic [7:0]  resp_r1, data_byte;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    always #5 clk = ~clk;

    sdctrl_spi_host dut (
        .i_clk(clk), .i_nrst(nrst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_cmd(req_cmd), .i_req_arg(req_arg), .i_req_mode(req_mode),
        .o_resp_valid(resp_valid), .o_resp_r1(resp_r1), .o_resp_data(resp_data), .o_resp_err(resp_err),
        .o_data_valid(data_valid), .o_data_byte(data_byte), .o_data_last(data_last),
        .o_csn(csn), .o_sck(sck), .o_mosi(mosi), .i_miso(miso)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // card model: logs MOSI bytes while CSn low; after the 7th byte (lead + command) returns scripted bytes
    logic [7:0] rq[$];
    logic [7:0] mosi_log[$];
    logic [7:0] in_sr = 8'hFF, out_sr = 8'hFF;
    int bitn = 0;

    always @(posedge sck) if (csn === 1'b0) begin
        in_sr = {in_sr[6:0], mosi};
        bitn++;
        if (bitn == 8) begin
            mosi_log.push_back(in_sr);
            bitn = 0;
        end
    end

    always @(negedge sck) if (csn === 1'b0) begin
        if (bitn == 0) begin
            if (mosi_log.size() >= 7 && rq.size() > 0) out_sr = rq.pop_front();
            else out_sr = 8'hFF;
        end else out_sr = {out_sr[6:0], 1'b1};
        miso = out_sr[7];
    end

    int init_sck = 0, init_mosi_bad = 0, rv_cnt = 0, last_cnt = 0, last_idx = -1;
    logic [7:0] dq[$];

    always @(posedge sck) if (csn === 1'b1) begin
        init_sck++;
        if (mosi !== 1'b1) init_mosi_bad++;
    end

    always @(negedge clk) begin
        if (resp_valid) rv_cnt++;
        if (data_valid) begin
            if (data_last) begin
                last_cnt++;
                last_idx = dq.size();
            end
            dq.push_back(data_byte);
        end
    end

    task automatic start(input logic [1:0] mode, input logic [5:0] cmd, input logic [31:0] arg);
        @(negedge clk);
        mosi_log.delete();
        bitn = 0;
        out_sr = 8'hFF;
        miso = 1'b1;
        req_valid = 1'b1;
        req_mode = mode;
        req_cmd = cmd;
        req_arg = arg;
        @(negedge clk);
        req_mode = 2'd3;
        req_cmd = 6'h3F;
        req_arg = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic txn(input logic [1:0] mode, input logic [5:0] cmd, input logic [31:0] arg, output logic ok);
        start(mode, cmd, arg);
        ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [15:0] crc16_blk(input int n);
        logic [15:0] c;
        logic [7:0]  b;
        c = '0;
        for (int i = 0; i < n; i++) begin
            b = 8'(i);
            for (int k = 7; k >= 0; k--)
                c = {c[14:0], 1'b0} ^ ((c[15] ^ b[k]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic load_block();
        logic [15:0] c;
        c = crc16_blk(512);
        rq.delete();
        rq.push_back(8'hFF); rq.push_back(8'h00);
        rq.push_back(8'hFF); rq.push_back(8'hFF); rq.push_back(8'hFE);
        for (int i = 0; i < 512; i++) rq.push_back(8'(i));
        rq.push_back(c[15:8]);
        rq.push_back(c[7:0]);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [5:0]  cmd;
        logic [31:0] arg;
        int          nr;
        logic [63:0] rb;
        logic [7:0]  crc;
        logic [7:0]  r1;
        logic [31:0] data;
        logic [1:0]  err;
        int          nbytes;
    } vec_t;

    vec_t v[9];

    initial begin
        logic ok;
        logic [47:0] f;
        int bad, rv0;
        v[0] = '{2'd0, 6'd0,  32'h0,        2, 64'hFF01_0000_0000_0000, 8'h95, 8'h01, 32'h0,        2'd0, 10};
        v[1] = '{2'd1, 6'd8,  32'h0000_01AA, 5, 64'h0100_0001_AA00_0000, 8'h87, 8'h01, 32'h0000_01AA, 2'd0, 13};
        v[2] = '{2'd1, 6'd58, 32'h0,        6, 64'hFF01_00FF_8000_0000, 8'hFD, 8'h01, 32'h00FF_8000, 2'd0, 14};
        v[3] = '{2'd0, 6'd55, 32'h0,        1, 64'h0100_0000_0000_0000, 8'h65, 8'h01, 32'h0,        2'd0, 9};
        v[4] = '{2'd0, 6'd41, 32'h4000_0000, 1, 64'h0000_0000_0000_0000, 8'h77, 8'h00, 32'h0,        2'd0, 9};
        v[5] = '{2'd0, 6'd0,  32'h0,        0, 64'h0,                   8'h95, 8'hFF, 32'h0,        2'd1, 16};
        v[6] = '{2'd0, 6'd0,  32'h0,        8, 64'hFFFF_FFFF_FFFF_FF01, 8'h95, 8'h01, 32'h0,        2'd0, 16};
        v[7] = '{2'd2, 6'd0,  32'h0,        1, 64'h0500_0000_0000_0000, 8'h95, 8'h05, 32'h0,        2'd0, 9};
        v[8] = '{2'd2, 6'd0,  32'h0,        4, 64'hFF00_FF08_0000_0000, 8'h95, 8'h00, 32'h0,        2'd2, 12};

        repeat (3) @(negedge clk);
        chk("rst csn", csn, 1); chk("rst sck", sck, 0); chk("rst mosi", mosi, 1);
        chk("rst ready", req_ready, 1); chk("rst resp_valid", resp_valid, 0);
        chk("rst r1", resp_r1, 0); chk("rst data", resp_data, 0); chk("rst err", resp_err, 0);
        chk("rst data_valid", data_valid, 0);
        nrst = 1'b1;

        init_sck = 0;
        init_mosi_bad = 0;
        txn(2'd3, 6'd0, 32'h0, ok);
        chk("init done", ok, 1);
        chk("init sck count", init_sck, 80);
        chk("init mosi high", init_mosi_bad, 0);
        chk("init csn low bytes", mosi_log.size(), 0);
        chk("init r1", resp_r1, 8'hFF);
        chk("init err", resp_err, 0);
        chk("init data", resp_data, 0);
        chk("init csn at done", csn, 1);

        for (int i = 0; i < 9; i++) begin
            rq.delete();
            for (int j = 0; j < v[i].nr; j++) rq.push_back(v[i].rb[63 - 8*j -: 8]);
            txn(v[i].mode, v[i].cmd, v[i].arg, ok);
            chk($sformatf("v%0d done", i), ok, 1);
            chk($sformatf("v%0d csn at done", i), csn, 1);
            chk($sformatf("v%0d r1", i), resp_r1, v[i].r1);
            chk($sformatf("v%0d data", i), resp_data, v[i].data);
            chk($sformatf("v%0d err", i), resp_err, v[i].err);
            chk($sformatf("v%0d nbytes", i), mosi_log.size(), v[i].nbytes);
            chk($sformatf("v%0d lead", i), mosi_log[0], 8'hFF);
            f = {2'b01, v[i].cmd, v[i].arg, v[i].crc};
            for (int k = 0; k < 6; k++)
                chk($sformatf("v%0d cmd byte%0d", i, k), mosi_log[1+k], f[47 - 8*k -: 8]);
            chk($sformatf("v%0d tail", i), mosi_log[mosi_log.size()-1], 8'hFF);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d r1 hold", i), resp_r1, v[i].r1);
            chk($sformatf("v%0d ready", i), req_ready, 1);
        end

        load_block();
        dq.delete();
        last_cnt = 0;
        last_idx = -1;
        txn(2'd2, 6'd18, 32'h0, ok);
        chk("blk done", ok, 1);
        chk("blk r1", resp_r1, 8'h00);
        chk("blk err", resp_err, 0);
        chk("blk data", resp_data, 0);
        chk("blk count", dq.size(), 512);
        bad = 0;
        for (int i = 0; i < dq.size(); i++) if (dq[i] !== 8'(i)) bad++;
        chk("blk byte values", bad, 0);
        chk("blk last count", last_cnt, 1);
        chk("blk last index", last_idx, 511);
        chk("blk mosi bytes", mosi_log.size(), 527);

        load_block();
        dq.delete();
        start(2'd2, 6'd18, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (dq.size() >= 10 && sck) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst mid-block reached", ok, 1);
        rv0 = rv_cnt;
        #2 nrst = 1'b0;
        #1;
        chk("rst mid csn", csn, 1);
        chk("rst mid sck", sck, 0);
        chk("rst mid ready", req_ready, 1);
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        rq.delete();
        repeat (200) @(negedge clk);
        chk("rst mid no resp", rv_cnt - rv0, 0);
        chk("rst mid idle csn", csn, 1);
        chk("rst mid idle ready", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
